// File: rtl/uart_tx_sched_if.sv
// Client handshake and serial-output bundle for uart_tx_sched.
interface uart_tx_sched_if;
  logic       req0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       ack1;
  logic       txd;
  logic       busy;
  logic       grant_id;

  modport master (
    output req0, data0, req1, data1,
    input  ack0, ack1, txd, busy, grant_id
  );

  modport slave (
    input  req0, data0, req1, data1,
    output ack0, ack1, txd, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-client round-robin UART transmit scheduler, 8N1 with restartable baud counter.
// Optional even-parity bit after the data byte: define UART_TX_SCHED_PARITY_EN.
module uart_tx_sched #(
  parameter int unsigned CLK_DIV = 5208,
  parameter int unsigned DIV_W   = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_sched_if.slave  bus
);

  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_SCHED_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [7:0]       sr;
  logic [2:0]       bit_idx;
  logic             last;
`ifdef UART_TX_SCHED_PARITY_EN
  logic             par;
`endif

  logic tick;
  logic pick1;

  assign tick  = (cnt == DIV_TC);
  // Client 1 wins when it is the only requester, or on a tie when client 0 was served last.
  assign pick1 = bus.req1 && (!bus.req0 || !last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      bit_idx      <= '0;
      last         <= 1'b1;
`ifdef UART_TX_SCHED_PARITY_EN
      par          <= 1'b0;
`endif
      bus.txd      <= 1'b1;
      bus.busy     <= 1'b0;
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      bus.grant_id <= 1'b0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      if (state != IDLE) begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            sr           <= pick1 ? bus.data1 : bus.data0;
`ifdef UART_TX_SCHED_PARITY_EN
            par          <= pick1 ? ^bus.data1 : ^bus.data0;
`endif
            last         <= pick1;
            bus.grant_id <= pick1;
            bus.ack0     <= !pick1;
            bus.ack1     <= pick1;
            bus.txd      <= 1'b0;
            bus.busy     <= 1'b1;
            cnt          <= '0;
            bit_idx      <= '0;
            state        <= START;
          end
        end

        START: begin
          if (tick) begin
            bus.txd <= sr[0];
            sr      <= {1'b0, sr[7:1]};
            state   <= DATA;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
              bus.txd <= par;
              state   <= PARITY;
`else
              bus.txd <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bus.txd <= sr[0];
              sr      <= {1'b0, sr[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

`ifdef UART_TX_SCHED_PARITY_EN
        PARITY: begin
          if (tick) begin
            bus.txd <= 1'b1;
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            bus.txd  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
